kyber_montgomery_mul_pipe: RTL

Multi-lane, fully pipelined Montgomery multiplier for Kyber arithmetic in Z_q. Each beat carries LANES signed 16-bit coefficient pairs. Per beat it computes either fqmul(a,b) = a*b*R^-1 mod q, or the to-Montgomery conversion a*R mod q (R = 2^16). It replaces the fixed single-lane reducer in the NTT/basemul datapath, adding valid/ready flow control with backpressure, a per-beat mode, a sideband tag and optional normalisation to [0,q).

---
 rtl/kyber_montgomery_mul_pipe_if.sv | 28 ++
 rtl/kyber_montgomery_mul_pipe.sv | 132 +++++++++++++
 2 files changed

// File: rtl/kyber_montgomery_mul_pipe_if.sv
// Beat-level handshake bundle for the multi-lane Montgomery multiplier.
// master drives operands and out_ready; slave is the multiplier itself.
interface kyber_montgomery_mul_pipe_if #(
    parameter int LANES   = 2,
    parameter int COEFF_W = 16,
    parameter int TAG_W   = 8
);
    logic                       in_valid;
    logic                       in_ready;
    logic                       in_mode;
    logic [TAG_W-1:0]           in_tag;
    logic [LANES*COEFF_W-1:0]   in_coeffs_a;
    logic [LANES*COEFF_W-1:0]   in_coeffs_b;
    logic                       out_valid;
    logic                       out_ready;
    logic [LANES*COEFF_W-1:0]   out_coeffs;
    logic [TAG_W-1:0]           out_tag;

    modport master (
        output in_valid, in_mode, in_tag, in_coeffs_a, in_coeffs_b, out_ready,
        input  in_ready, out_valid, out_coeffs, out_tag
    );

    modport slave (
        input  in_valid, in_mode, in_tag, in_coeffs_a, in_coeffs_b, out_ready,
        output in_ready, out_valid, out_coeffs, out_tag
    );
endinterface

// File: rtl/kyber_montgomery_mul_pipe.sv
// Multi-lane three-stage Montgomery multiplier for Kyber Z_q arithmetic.
// Mode 0: a*b*R^-1 mod q.  Mode 1: a*R mod q (b replaced by R^2 mod q).
// The whole pipe advances together; a stalled output freezes every stage.
module kyber_montgomery_mul_pipe #(
    parameter int LANES     = 2,
    parameter int KYBER_Q   = 3329,
    parameter int QINV      = 62209,
    parameter int R2_MOD_Q  = 1353,
    parameter int COEFF_W   = 16,
    parameter int TAG_W     = 8,
    parameter int NORMALIZE = 0
) (
    input logic                        clk,
    input logic                        reset,
    kyber_montgomery_mul_pipe_if.slave bus
);
    localparam int PROD_W = 2 * COEFF_W;

    // QINV is consumed as its signed 16-bit reinterpretation (-3327).
    localparam logic signed [COEFF_W-1:0] QINV_S = COEFF_W'(QINV);
    localparam logic signed [COEFF_W-1:0] R2_S   = COEFF_W'(R2_MOD_Q);
    localparam logic signed [COEFF_W-1:0] Q_S    = COEFF_W'(KYBER_Q);
    localparam logic signed [PROD_W-1:0]  Q_W    = PROD_W'(KYBER_Q);

    // Montgomery factor u = low16(t * QINV), read back as signed.
    function automatic logic signed [COEFF_W-1:0] mont_factor(
        input logic signed [PROD_W-1:0] t
    );
        logic signed [PROD_W-1:0] prod;
        prod = t * PROD_W'(QINV_S);
        return COEFF_W'(prod);
    endfunction

    // (t - u*q) has zero low half by construction of u; keep the high half.
    function automatic logic signed [COEFF_W-1:0] mont_reduce(
        input logic signed [PROD_W-1:0]  t,
        input logic signed [COEFF_W-1:0] u
    );
        logic signed [PROD_W-1:0] diff;
        diff = t - PROD_W'(u) * Q_W;
        return COEFF_W'(diff >>> COEFF_W);
    endfunction

    // Optional fold of (-q,0) into [0,q); identity when normalisation is off.
    function automatic logic signed [COEFF_W-1:0] fold_positive(
        input logic signed [COEFF_W-1:0] r
    );
        if (NORMALIZE != 0 && r[COEFF_W-1]) begin
            return r + Q_S;
        end
        return r;
    endfunction

    logic                       en;
    logic                       vld_p1, vld_p2, vld_p3;
    logic [TAG_W-1:0]           tag_p1, tag_p2, tag_p3;
    logic signed [COEFF_W-1:0]  a_lane [LANES];
    logic signed [COEFF_W-1:0]  b_lane [LANES];
    logic signed [PROD_W-1:0]   t_p1   [LANES];
    logic signed [PROD_W-1:0]   t_p2   [LANES];
    logic signed [COEFF_W-1:0]  u_p2   [LANES];
    logic signed [COEFF_W-1:0]  r_p3   [LANES];

    // Pipe advances whenever the output stage is empty or being drained.
    always_comb begin
        en           = !vld_p3 || bus.out_ready;
        bus.in_ready = en;
        bus.out_valid = vld_p3;
        bus.out_tag   = tag_p3;
    end

    // Unpack operand lanes and pick the b operand according to the beat mode.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            a_lane[i] = bus.in_coeffs_a[i*COEFF_W +: COEFF_W];
            b_lane[i] = bus.in_mode ? R2_S : bus.in_coeffs_b[i*COEFF_W +: COEFF_W];
        end
    end

    // Pack the per-lane results onto the output bus.
    always_comb begin
        bus.out_coeffs = '0;
        for (int i = 0; i < LANES; i++) begin
            bus.out_coeffs[i*COEFF_W +: COEFF_W] = r_p3[i];
        end
    end

    // Valid bits shift together; a reset drops every in-flight beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
            vld_p3 <= 1'b0;
        end else if (en) begin
            vld_p1 <= bus.in_valid;
            vld_p2 <= vld_p1;
            vld_p3 <= vld_p2;
        end
    end

    // Datapath stages move in lockstep with the valid bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_p1 <= '0;
            tag_p2 <= '0;
            tag_p3 <= '0;
            for (int i = 0; i < LANES; i++) begin
                t_p1[i] <= '0;
                t_p2[i] <= '0;
                u_p2[i] <= '0;
                r_p3[i] <= '0;
            end
        end else if (en) begin
            // S1: full signed product
            tag_p1 <= bus.in_tag;
            for (int i = 0; i < LANES; i++) begin
                t_p1[i] <= PROD_W'(a_lane[i]) * PROD_W'(b_lane[i]);
            end
            // S2: Montgomery factor, product carried alongside
            tag_p2 <= tag_p1;
            for (int i = 0; i < LANES; i++) begin
                t_p2[i] <= t_p1[i];
                u_p2[i] <= mont_factor(t_p1[i]);
            end
            // S3: reduction and optional normalisation
            tag_p3 <= tag_p2;
            for (int i = 0; i < LANES; i++) begin
                r_p3[i] <= fold_positive(mont_reduce(t_p2[i], u_p2[i]));
            end
        end
    end
endmodule
